// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: state and cause encodings shared by the reset sequencer files.
package rst_seq_pkg;
   typedef enum logic [1:0] {HOLD = 2'd0, WAIT_REL = 2'd1, RUN = 2'd2} state_e;
   typedef enum logic [1:0] {CAUSE_POR = 2'd0, CAUSE_BTN = 2'd1, CAUSE_WDT = 2'd2} cause_e;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/btn_debouncer.sv
// btn_debouncer: synchronizes the raw button, debounces it and flags debounced presses.
module btn_debouncer
   import rst_seq_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic Clk,
   input  logic Reset,
   input  logic Btn,
   output logic Level,
   output logic Press
);
   localparam int CW = cnt_w(DEBOUNCE_CYCLES);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYCLES - 1))
            level_d = ~level_q;
         else
            cnt_d = cnt_q + 1'b1;
      end
      press_d = level_d & ~level_q;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= Btn;
         sync2_q <= sync1_q;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign Level = level_q;
   assign Press = press_q;
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: stretches POR, button and watchdog resets into clean Cpu_Rst pulses.
module reset_sequencer
   import rst_seq_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int HOLD_CYCLES     = 8,
   parameter int WDT_CYCLES      = 1024
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Btn_Rst,
   input  logic       Wdt_En,
   input  logic       Wdt_Kick,
   output logic       Cpu_Rst,
   output logic [1:0] Rst_Cause,
   output logic       Rst_Done
);
   localparam int HW = cnt_w(HOLD_CYCLES);
   localparam int WW = cnt_w(WDT_CYCLES);

   state_e        state_q, state_d;
   cause_e        cause_q, cause_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [WW-1:0] wdt_q, wdt_d;
   logic          cpu_rst_q, cpu_rst_d;
   logic          done_q, done_d;
   logic          level, press;

   btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .Clk   (Clk),
      .Reset (Reset),
      .Btn   (Btn_Rst),
      .Level (level),
      .Press (press)
   );

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      hold_d  = (state_q == HOLD) ? hold_q + 1'b1 : '0;
      wdt_d   = '0;
      if (state_q == HOLD) begin
         if (hold_q == HW'(HOLD_CYCLES - 1))
            state_d = (cause_q == CAUSE_BTN && level) ? WAIT_REL : RUN;
      end else if (state_q == WAIT_REL) begin
         if (!level)
            state_d = RUN;
      end else if (state_q == RUN) begin
         wdt_d = (!Wdt_En || Wdt_Kick) ? '0 : wdt_q + 1'b1;
         // button outranks a coincident watchdog expiry; a kick cancels expiry
         if (press) begin
            state_d = HOLD;
            cause_d = CAUSE_BTN;
         end else if (Wdt_En && !Wdt_Kick && wdt_q == WW'(WDT_CYCLES - 1)) begin
            state_d = HOLD;
            cause_d = CAUSE_WDT;
         end
      end else begin
         state_d = HOLD;
      end
      if (state_d == HOLD && state_q != HOLD) begin
         hold_d = '0;
         wdt_d  = '0;
      end
      cpu_rst_d = (state_d != RUN);
      done_d    = cpu_rst_q & ~cpu_rst_d;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q   <= HOLD;
         cause_q   <= CAUSE_POR;
         hold_q    <= '0;
         wdt_q     <= '0;
         cpu_rst_q <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cause_q   <= cause_d;
         hold_q    <= hold_d;
         wdt_q     <= wdt_d;
         cpu_rst_q <= cpu_rst_d;
         done_q    <= done_d;
      end
   end

   assign Cpu_Rst   = cpu_rst_q;
   assign Rst_Cause = cause_q;
   assign Rst_Done  = done_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed checks of POR, button, glitch, watchdog and async reset behaviour.
module tb_reset_sequencer;
   logic       Clk = 1'b0;
   logic       Reset, Btn_Rst, Wdt_En, Wdt_Kick;
   logic       Cpu_Rst, Rst_Done;
   logic [1:0] Rst_Cause;
   int         errors = 0;
   int         checks = 0;

   always #5 Clk = ~Clk;

   reset_sequencer #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(8), .WDT_CYCLES(32)) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .Btn_Rst   (Btn_Rst),
      .Wdt_En    (Wdt_En),
      .Wdt_Kick  (Wdt_Kick),
      .Cpu_Rst   (Cpu_Rst),
      .Rst_Cause (Rst_Cause),
      .Rst_Done  (Rst_Done)
   );

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge Clk);
   endtask

   // edge e counts rising edges after Reset drops; Cpu_Rst falls on edge 8
   task automatic por_run(input string tag);
      for (int e = 1; e <= 9; e++) begin
         step();
         check({tag, "_cpu"}, Cpu_Rst, (e < 8) ? 1 : 0);
         check({tag, "_done"}, Rst_Done, (e == 8) ? 1 : 0);
         check({tag, "_cause"}, Rst_Cause, 0);
      end
   endtask

   task automatic assert_reset(input string tag);
      Reset = 1'b1;
      #1;
      check({tag, "_cpu"}, Cpu_Rst, 1);
      check({tag, "_cause"}, Rst_Cause, 0);
      check({tag, "_done"}, Rst_Done, 0);
   endtask

   initial begin
      Reset = 1'b1; Btn_Rst = 1'b0; Wdt_En = 1'b0; Wdt_Kick = 1'b0;
      repeat (10) step();
      check("rst_cpu", Cpu_Rst, 1);
      check("rst_cause", Rst_Cause, 0);
      check("rst_done", Rst_Done, 0);
      Reset = 1'b0;
      por_run("por");

      // button held 20 cycles: rise on edge 7, WAIT_REL until debounced release
      Btn_Rst = 1'b1;
      for (int e = 1; e <= 30; e++) begin
         step();
         check("btn_cpu", Cpu_Rst, (e >= 7 && e < 27) ? 1 : 0);
         check("btn_done", Rst_Done, (e == 27) ? 1 : 0);
         if (e >= 7) check("btn_cause", Rst_Cause, 1);
         if (e == 20) Btn_Rst = 1'b0;
      end

      Btn_Rst = 1'b1;
      step();
      step();
      Btn_Rst = 1'b0;
      for (int e = 1; e <= 20; e++) begin
         step();
         check("glitch_cpu", Cpu_Rst, 0);
      end

      Wdt_En = 1'b1;
      for (int c = 1; c <= 500; c++) begin
         step();
         check("wdt_kicked_cpu", Cpu_Rst, 0);
         Wdt_Kick = (c % 20 == 0);
      end
      step();
      Wdt_Kick = 1'b0;
      // last kick on edge 0: expiry on edge 32, release on 40, kick on the next expiry cycle (edge 72)
      for (int e = 1; e <= 80; e++) begin
         step();
         check("wdt_cpu", Cpu_Rst, (e >= 32 && e < 40) ? 1 : 0);
         check("wdt_done", Rst_Done, (e == 40) ? 1 : 0);
         if (e >= 32) check("wdt_cause", Rst_Cause, 2);
         Wdt_Kick = (e == 71);
      end
      Wdt_En = 1'b0;
      for (int e = 1; e <= 40; e++) begin
         step();
         check("wdt_off_cpu", Cpu_Rst, 0);
      end

      Btn_Rst = 1'b1;
      repeat (20) step();
      check("wr_cpu", Cpu_Rst, 1);
      check("wr_cause", Rst_Cause, 1);
      assert_reset("mid_wait");
      Btn_Rst = 1'b0;
      step();
      step();
      Reset = 1'b0;
      por_run("por_after_wait");

      Btn_Rst = 1'b1;
      repeat (4) step();
      check("deb_cpu", Cpu_Rst, 0);
      assert_reset("mid_deb");
      Btn_Rst = 1'b0;
      step();
      step();
      Reset = 1'b0;
      por_run("por_after_deb");
      for (int e = 1; e <= 12; e++) begin
         step();
         check("deb_quiet_cpu", Cpu_Rst, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
